// File: rtl/pixel_stream_tx.sv
// Frame-buffer reader driving a Frame/Line/Pixel stream; strobes and pixels trail the FSM by 3 cycles to cover the RAM read.
// Optional TESTPATTERN_EN adds PatternSel, which replaces RAM data with (col + row) and parks RdAddr at 0.
module pixel_stream_tx #(
  parameter int HBLANK = 2,
  parameter int VBLANK = 4,
  parameter int ADDR_W = 16
) (
  input  logic              Clk,
  input  logic              nReset,
  input  logic              Start,
  input  logic [7:0]        Width,
  input  logic [7:0]        Height,
  output logic [ADDR_W-1:0] RdAddr,
  input  logic [7:0]        RdData,
  output logic [7:0]        PixelOut,
  output logic              FrameOut,
  output logic              LineOut,
  output logic              Busy,
  output logic              Done
`ifdef TESTPATTERN_EN
  ,
  input  logic              PatternSel
`endif
);

  typedef enum logic [2:0] {
    stIdle,
    stFrame,
    stLine,
    stPixel,
    stHblank,
    stVblank,
    stDone
  } state_t;

  state_t state, nextState;

  logic [7:0]        widthLat, heightLat;
  logic [7:0]        col, row;
  logic [15:0]       blankCnt;
  logic [ADDR_W-1:0] rowBase;
  logic              accept, lastCol, lastBlankH, lastBlankV, lastRow;

  // Strobe pipeline: stage 1 lines up with RdAddr, stage 2 with RdData.
  logic frameD1, frameD2, lineD1, lineD2, pixD1, pixD2, doneD1;

`ifdef TESTPATTERN_EN
  logic       patLat;
  logic [7:0] patVal1, patVal2;
`endif

  // Busy still covers the two cycles Done trails the FSM, so no new frame can overlap the tail.
  assign accept     = (state == stIdle) && !Busy && Start && (Width != 8'd0) && (Height != 8'd0);
  assign lastCol    = (col == widthLat - 8'd1);
  assign lastRow    = (row == heightLat - 8'd1);
  assign lastBlankH = (blankCnt == 16'(HBLANK - 1));
  assign lastBlankV = (blankCnt == 16'(VBLANK - 1));

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) state <= stIdle;
    else         state <= nextState;
  end

  always_comb begin
    nextState = state;
    unique case (state)
      stIdle:   if (accept) nextState = stFrame;
      stFrame:  nextState = stLine;
      stLine:   nextState = stPixel;
      stPixel:  if (lastCol) nextState = stHblank;
      stHblank: if (lastBlankH) nextState = lastRow ? stVblank : stLine;
      stVblank: if (lastBlankV) nextState = stDone;
      stDone:   nextState = stIdle;
      default:  nextState = stIdle;
    endcase
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      widthLat  <= 8'd0;
      heightLat <= 8'd0;
      col       <= 8'd0;
      row       <= 8'd0;
      blankCnt  <= 16'd0;
      rowBase   <= '0;
      RdAddr    <= '0;
    end else begin
      if (accept) begin
        widthLat  <= Width;
        heightLat <= Height;
      end
      blankCnt <= (nextState != state) ? 16'd0 : blankCnt + 16'd1;
      case (state)
        stFrame: begin
          row     <= 8'd0;
          rowBase <= '0;
        end
        stLine:  col <= 8'd0;
        stPixel: begin
          col <= col + 8'd1;
          if (lastCol) rowBase <= rowBase + ADDR_W'(widthLat);
        end
        stHblank: if (lastBlankH && !lastRow) row <= row + 8'd1;
        default: ;
      endcase
`ifdef TESTPATTERN_EN
      if (accept && PatternSel)
        RdAddr <= '0;
      else if (state == stPixel && !patLat)
        RdAddr <= rowBase + ADDR_W'(col);
`else
      if (state == stPixel)
        RdAddr <= rowBase + ADDR_W'(col);
`endif
    end
  end

`ifdef TESTPATTERN_EN
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      patLat  <= 1'b0;
      patVal1 <= 8'd0;
      patVal2 <= 8'd0;
    end else begin
      if (accept) patLat <= PatternSel;
      patVal1 <= col + row;
      patVal2 <= patVal1;
    end
  end
`endif

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      frameD1  <= 1'b0;
      frameD2  <= 1'b0;
      lineD1   <= 1'b0;
      lineD2   <= 1'b0;
      pixD1    <= 1'b0;
      pixD2    <= 1'b0;
      doneD1   <= 1'b0;
      FrameOut <= 1'b0;
      LineOut  <= 1'b0;
      PixelOut <= 8'h00;
      Done     <= 1'b0;
      Busy     <= 1'b0;
    end else begin
      frameD1  <= (state == stFrame);
      frameD2  <= frameD1;
      FrameOut <= frameD2;
      lineD1   <= (state == stLine);
      lineD2   <= lineD1;
      LineOut  <= lineD2;
      pixD1    <= (state == stPixel);
      pixD2    <= pixD1;
`ifdef TESTPATTERN_EN
      PixelOut <= pixD2 ? (patLat ? patVal2 : RdData) : 8'h00;
`else
      PixelOut <= pixD2 ? RdData : 8'h00;
`endif
      doneD1   <= (state == stDone);
      Done     <= doneD1;
      if (accept)    Busy <= 1'b1;
      else if (Done) Busy <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pixel_stream_tx.sv
// Directed bench for pixel_stream_tx: synchronous RAM model, strobe/pixel capture, timed checks.
module tb_pixel_stream_tx;

  logic        Clk = 1'b0;
  logic        nReset = 1'b0;
  logic        Start = 1'b0;
  logic [7:0]  Width = 8'd0;
  logic [7:0]  Height = 8'd0;
  logic [15:0] RdAddr;
  logic [7:0]  RdData = 8'h00;
  logic [7:0]  PixelOut;
  logic        FrameOut, LineOut, Busy, Done;
`ifdef TESTPATTERN_EN
  logic        PatternSel = 1'b0;
`endif

  pixel_stream_tx #(.HBLANK(2), .VBLANK(4), .ADDR_W(16)) dut (
    .Clk(Clk), .nReset(nReset), .Start(Start), .Width(Width), .Height(Height),
    .RdAddr(RdAddr), .RdData(RdData), .PixelOut(PixelOut), .FrameOut(FrameOut),
    .LineOut(LineOut), .Busy(Busy), .Done(Done)
`ifdef TESTPATTERN_EN
    , .PatternSel(PatternSel)
`endif
  );

  always #5 Clk = ~Clk;

  logic [7:0] ramXor = 8'h00;
  always @(posedge Clk) RdData <= RdAddr[7:0] ^ ramXor;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  // Monitor state, written only here.
  int         frameCnt = 0, lineCnt = 0, doneCnt = 0;
  int         frameCyc = 0, doneCyc = 0, idleBad = 0, collide = 0, pixLeft = 0;
  int         lineQ[$];
  logic [7:0] pixQ[$];
  logic       prevDone = 1'b0, busyAtDone = 1'b0, busyAfterDone = 1'b1;
  int         curW = 0;

  always @(negedge Clk) begin
    prevDone <= Done;
    if (!nReset) begin
      pixLeft <= 0;
    end else begin
      if (FrameOut) begin
        frameCnt <= frameCnt + 1;
        frameCyc <= cyc;
      end
      if (LineOut) begin
        lineCnt <= lineCnt + 1;
        lineQ.push_back(cyc);
      end
      if (FrameOut && LineOut) collide <= collide + 1;
      if (Done) begin
        doneCnt    <= doneCnt + 1;
        doneCyc    <= cyc;
        busyAtDone <= Busy;
      end
      if (prevDone) busyAfterDone <= Busy;
      if (LineOut) begin
        pixLeft <= curW;
      end else if (pixLeft > 0) begin
        pixQ.push_back(PixelOut);
        pixLeft <= pixLeft - 1;
      end else if (PixelOut !== 8'h00) begin
        idleBad <= idleBad + 1;
      end
    end
  end

  int nAsserts = 0;
  int nFail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic startFrame(input logic [7:0] w, input logic [7:0] h, output int s);
    Width  = w;
    Height = h;
    Start  = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    s = cyc;
  endtask

  task automatic waitDone(input int budget, input int base);
    for (int i = 0; i < budget; i++) begin
      @(negedge Clk);
      if (doneCnt != base) break;
    end
    repeat (4) @(negedge Clk);
  endtask

  task automatic checkResetOutputs(input string tag);
    check({tag, "_pixel"}, PixelOut, 8'h00);
    check({tag, "_frame"}, FrameOut, 1'b0);
    check({tag, "_line"},  LineOut,  1'b0);
    check({tag, "_addr"},  RdAddr,   16'h0000);
    check({tag, "_busy"},  Busy,     1'b0);
    check({tag, "_done"},  Done,     1'b0);
  endtask

  int s, fb, lb, db, pb, qb;
  logic [7:0] expA[8];
  logic [7:0] expD[8];

  initial begin
    expA = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
    expD = '{8'h3C, 8'h3D, 8'h3E, 8'h3F, 8'h38, 8'h39, 8'h3A, 8'h3B};

    repeat (3) @(negedge Clk);
    checkResetOutputs("reset");
    nReset = 1'b1;
    repeat (2) @(negedge Clk);

    // 4x2 frame; a Start with new dimensions arrives mid-frame and must be ignored.
    curW = 4; ramXor = 8'h00;
    fb = frameCnt; lb = lineCnt; db = doneCnt; pb = pixQ.size(); qb = lineQ.size();
    startFrame(8'd4, 8'd2, s);
    check("a_busy_rise", Busy, 1'b1);
    repeat (4) @(negedge Clk);
    Width = 8'd3; Height = 8'd3; Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    waitDone(200, db);
    check("a_frames", frameCnt - fb, 1);
    check("a_lines", lineCnt - lb, 2);
    check("a_dones", doneCnt - db, 1);
    check("a_pixcount", pixQ.size() - pb, 8);
    check("a_frame_cyc", frameCyc - s, 3);
    check("a_line0_cyc", lineQ[qb] - s, 4);
    check("a_line1_cyc", lineQ[qb+1] - s, 11);
    check("a_done_cyc", doneCyc - s, 21);
    check("a_busy_at_done", busyAtDone, 1'b1);
    check("a_busy_after_done", busyAfterDone, 1'b0);
    check("a_last_addr", RdAddr, 16'h0007);
    for (int i = 0; i < 8; i++) check($sformatf("a_pix%0d", i), pixQ[pb+i], expA[i]);

    // Zero width: Start must be ignored entirely.
    fb = frameCnt; db = doneCnt;
    Width = 8'd0; Height = 8'd5; Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    repeat (2) @(negedge Clk);
    check("zw_busy_early", Busy, 1'b0);
    repeat (10) @(negedge Clk);
    check("zw_busy_late", Busy, 1'b0);
    check("zw_frames", frameCnt - fb, 0);
    check("zw_dones", doneCnt - db, 0);

    // Reset during pixel 2 of row 0.
    curW = 4; ramXor = 8'h00;
    startFrame(8'd4, 8'd2, s);
    repeat (7) @(negedge Clk);
    check("c_pix2_before_reset", PixelOut, 8'h02);
    nReset = 1'b0;
    #1;
    checkResetOutputs("abort");
    @(negedge Clk);
    nReset = 1'b1;
    fb = frameCnt; lb = lineCnt; db = doneCnt;
    repeat (12) @(negedge Clk);
    check("c_no_frame_after", frameCnt - fb, 0);
    check("c_no_line_after", lineCnt - lb, 0);
    check("c_no_done_after", doneCnt - db, 0);
    check("c_busy_after", Busy, 1'b0);

    // Full frame after abort restarts from address 0.
    ramXor = 8'h3C;
    fb = frameCnt; lb = lineCnt; db = doneCnt; pb = pixQ.size();
    startFrame(8'd4, 8'd2, s);
    waitDone(200, db);
    check("d_frames", frameCnt - fb, 1);
    check("d_lines", lineCnt - lb, 2);
    check("d_frame_cyc", frameCyc - s, 3);
    check("d_done_cyc", doneCyc - s, 21);
    for (int i = 0; i < 8; i++) check($sformatf("d_pix%0d", i), pixQ[pb+i], expD[i]);

    // Single pixel frame.
    curW = 1; ramXor = 8'hA5;
    fb = frameCnt; lb = lineCnt; db = doneCnt; pb = pixQ.size(); qb = lineQ.size();
    startFrame(8'd1, 8'd1, s);
    waitDone(100, db);
    check("e_frames", frameCnt - fb, 1);
    check("e_lines", lineCnt - lb, 1);
    check("e_line_cyc", lineQ[qb] - s, 4);
    check("e_pixcount", pixQ.size() - pb, 1);
    check("e_pix0", pixQ[pb], 8'hA5);
    check("e_done_cyc", doneCyc - s, 11);
    check("e_dones", doneCnt - db, 1);

    // Maximum 255x255 frame.
    curW = 255; ramXor = 8'h00;
    fb = frameCnt; lb = lineCnt; db = doneCnt; pb = pixQ.size();
    startFrame(8'd255, 8'd255, s);
    waitDone(70000, db);
    check("f_frames", frameCnt - fb, 1);
    check("f_lines", lineCnt - lb, 255);
    check("f_pixcount", pixQ.size() - pb, 65025);
    check("f_dones", doneCnt - db, 1);
    check("f_final_addr", RdAddr, 16'hFE00);
    check("f_last_pix", pixQ[pixQ.size()-1], 8'h00);
    check("f_second_last_pix", pixQ[pixQ.size()-2], 8'hFF);
    check("f_busy_after", Busy, 1'b0);

`ifdef TESTPATTERN_EN
    curW = 3; ramXor = 8'h77; PatternSel = 1'b1;
    pb = pixQ.size(); db = doneCnt;
    startFrame(8'd3, 8'd2, s);
    PatternSel = 1'b0;
    check("g_addr_start", RdAddr, 16'h0000);
    waitDone(200, db);
    check("g_addr_end", RdAddr, 16'h0000);
    check("g_pix0", pixQ[pb],   8'h00);
    check("g_pix1", pixQ[pb+1], 8'h01);
    check("g_pix2", pixQ[pb+2], 8'h02);
    check("g_pix3", pixQ[pb+3], 8'h01);
    check("g_pix4", pixQ[pb+4], 8'h02);
    check("g_pix5", pixQ[pb+5], 8'h03);
`endif

    check("idle_pixels_zero", idleBad, 0);
    check("frame_line_collide", collide, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
    $finish;
  end

endmodule
